muxn_scan: RTL
==============

Name: muxn_scan

Overview:
Parametrised N-to-1 selector, successor to the combinational 2-1 selector, with a registered output, per-channel enable mask and two modes. Manual mode follows an external select; auto mode scans the enabled channels round-robin, dwelling a fixed number of cycles on each. It sits in front of display and measurement logic that time-shares one W-bit path between several sources.

Parameters:
WIDTH, 8, data width per channel (>=1)
NCH, 4, number of input channels (2..16)
DWELL, 4, cycles spent on each channel in auto mode (>=1)
SELW, derived as clog2(NCH) with a minimum of 1, local parameter, select/channel index width

Ports:
CLK    in   1            clock; all state updates on rising edge
RST_N  in   1            asynchronous active-low reset
D      in   NCH*WIDTH    flattened inputs; channel k = D[k*WIDTH +: WIDTH]
SEL    in   SELW         manual channel select
MODE   in   1            0 = manual, 1 = auto scan
EN     in   NCH          channel enable mask; bit k enables channel k
Y      out  WIDTH        registered selected data
CH     out  SELW         index of the channel driving Y
VALID  out  1            Y holds fresh data from an enabled channel
ADV    out  1            one-cycle pulse: CH changed in the current cycle

Behaviour:
- Reset (RST_N=0, asynchronous): Y=0, CH=0, VALID=0, ADV=0, dwell counter=0. Outputs hold these values while RST_N is low.
- Release: first update on the first rising CLK edge after RST_N goes high.
- Latency: Y, CH and VALID reflect the inputs sampled at the previous edge (1 cycle). Y re-samples D[CH] every cycle while VALID, so data changes on the current channel appear after 1 cycle.
- Manual mode (MODE=0):
  - SEL<NCH and EN[SEL]=1: CH<=SEL, Y<=D[SEL], VALID<=1.
  - Otherwise (SEL out of range or disabled): Y and CH hold, VALID<=0.
  - ADV=1 in a cycle where CH changes value. The dwell counter is held at 0.
- Auto mode (MODE=1), dwell counter cnt runs 0..DWELL-1:
  - Current CH enabled and cnt<DWELL-1: cnt++, Y<=D[CH], VALID<=1.
  - Current CH enabled and cnt==DWELL-1: CH<=next enabled channel after CH, searching upward and wrapping past NCH-1 to 0. Then cnt<=0, Y<=D[new CH], ADV<=1.
  - Only one channel enabled: CH stays, cnt wraps, Y keeps updating, ADV=0.
  - Current CH disabled (EN cleared mid-dwell): jump to the next enabled channel on the next edge regardless of cnt, then cnt<=0 and ADV<=1.
  - EN=0 (nothing enabled): Y and CH hold, VALID<=0, cnt<=0, ADV=0.
- Mode switching:
  - Manual to auto: scanning starts from the current CH with cnt=0. No advance occurs on the switching edge unless CH is disabled.
  - Auto to manual: the next edge follows SEL per the manual rules. cnt is cleared.
- Reset mid-scan: returns to CH=0, cnt=0 asynchronously. After release, scanning restarts at channel 0 if it is enabled; otherwise it jumps to the next enabled channel on the first edge.
- DWELL=1: advances every cycle and ADV stays high while 2 or more channels are enabled.
- No combinational path from any input to any output.

Test Plan:
All cases use WIDTH=8, NCH=4, DWELL=4, channels 0..3 = 8'h11, 8'h22, 8'h33, 8'h44.
- Reset: RST_N=0 asserted between edges -> Y=00, CH=0, VALID=0, ADV=0 immediately, with no clock edge needed.
- Manual: EN=4'hF, MODE=0, SEL=0,1,2,3 held 20ns each -> Y = 11, 22, 33, 44, each 1 cycle after the SEL change; VALID=1; ADV pulses once per change.
- Manual, disabled channel: EN=4'b1011, SEL=2 -> Y holds the previous value, VALID=0. Then D ch0 changes to 8'h5A with SEL=0 -> Y=5A on the next cycle.
- Auto scan: EN=4'b1101, MODE=1 from CH=0 -> Y sequence 11 x4, 33 x4, 44 x4, 11 (channel 1 skipped, wrap from 3 to 0); ADV is high on the first cycle of each new channel.
- Auto, mask changes: EN changes from 4'hF to 4'b0001 at cnt=1 on CH=2 -> next edge CH=0, Y=11, ADV=1, then CH stays 0. EN=0 -> VALID=0, Y holds.
- Reset mid-operation: RST_N pulsed low while CH=3 in auto mode -> all outputs cleared. After release with EN=4'b1110, the first edge gives CH=1, Y=22.

Source files
------------

// File: rtl/muxn_scan.sv
// N-to-1 registered selector. Manual mode follows SEL; auto mode walks the
// enabled channels round-robin, dwelling DWELL cycles on each.
module muxn_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int DWELL = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NCH*WIDTH-1:0]   D,
    input  logic [SELW-1:0]        SEL,
    input  logic                   MODE,
    input  logic [NCH-1:0]         EN,
    output logic [WIDTH-1:0]       Y,
    output logic [SELW-1:0]        CH,
    output logic                   VALID,
    output logic                   ADV
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0]    cnt;
    logic [SELW-1:0]  nxt_ch;
    logic             sel_ok;
    logic             ch_en;
    logic             dwell_done;
    logic [WIDTH-1:0] d_sel;
    logic [WIDTH-1:0] d_ch;
    logic [WIDTH-1:0] d_nxt;

    // Next enabled channel strictly after CH, wrapping; CH itself if it is the only one.
    always_comb begin
        logic found;
        int unsigned idx;
        nxt_ch = CH;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(CH) + k) % NCH;
            if (!found && EN[idx]) begin
                nxt_ch = SELW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ok     = (32'(SEL) < NCH) ? EN[SEL] : 1'b0;
        ch_en      = (32'(CH) < NCH) ? EN[CH] : 1'b0;
        dwell_done = (32'(cnt) == DWELL - 1);
        d_sel      = '0;
        d_ch       = '0;
        d_nxt      = '0;
        if (32'(SEL) < NCH)
            d_sel = D[32'(SEL)*WIDTH +: WIDTH];
        if (32'(CH) < NCH)
            d_ch = D[32'(CH)*WIDTH +: WIDTH];
        if (32'(nxt_ch) < NCH)
            d_nxt = D[32'(nxt_ch)*WIDTH +: WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Y     <= '0;
            CH    <= '0;
            VALID <= 1'b0;
            ADV   <= 1'b0;
            cnt   <= '0;
        end else if (!MODE) begin
            cnt <= '0;
            if (sel_ok) begin
                CH    <= SEL;
                Y     <= d_sel;
                VALID <= 1'b1;
                ADV   <= (SEL != CH);
            end else begin
                VALID <= 1'b0;
                ADV   <= 1'b0;
            end
        end else if (EN == '0) begin
            VALID <= 1'b0;
            ADV   <= 1'b0;
            cnt   <= '0;
        end else if (!ch_en || dwell_done) begin
            // A disabled current channel forces an immediate hop regardless of cnt.
            CH    <= nxt_ch;
            Y     <= d_nxt;
            VALID <= 1'b1;
            ADV   <= (nxt_ch != CH);
            cnt   <= '0;
        end else begin
            Y     <= d_ch;
            VALID <= 1'b1;
            ADV   <= 1'b0;
            cnt   <= cnt + 1'b1;
        end
    end

endmodule
